// File: rtl/dram_arbiter_if.sv
// dram_arbiter_if: per-core request, downstream command and read-return
// signals shared between dram_arbiter (slave) and its cores/DRAM (master).
// With DRAM_ARB_STAT_EN defined the bundle also carries o_grant_cnts.
interface dram_arbiter_if #(
   parameter int N_REQ   = 4,
   parameter int ADDR_BW = 32,
   parameter int LINE_BW = 512
);
   logic [N_REQ-1:0]         i_ra_rdys;
   logic [N_REQ-1:0]         o_ra_acks;
   logic [N_REQ*ADDR_BW-1:0] i_ra_addrs;
   logic [N_REQ-1:0]         i_w_rdys;
   logic [N_REQ-1:0]         o_w_acks;
   logic [N_REQ*ADDR_BW-1:0] i_w_addrs;
   logic [N_REQ*LINE_BW-1:0] i_w_datas;
   logic                     o_dram_rdy;
   logic                     i_dram_ack;
   logic                     o_dram_we;
   logic [ADDR_BW-1:0]       o_dram_addr;
   logic [LINE_BW-1:0]       o_dram_wdata;
   logic                     i_dramrd_rdy;
   logic                     o_dramrd_ack;
   logic [LINE_BW-1:0]       i_dramrd_data;
   logic [N_REQ-1:0]         o_rd_rdys;
   logic [N_REQ-1:0]         i_rd_acks;
   logic [LINE_BW-1:0]       o_rd_data;
   logic                     o_err;
`ifdef DRAM_ARB_STAT_EN
   logic [N_REQ*16-1:0]      o_grant_cnts;
`endif

   modport slave (
`ifdef DRAM_ARB_STAT_EN
      output o_grant_cnts,
`endif
      input  i_ra_rdys, i_ra_addrs, i_w_rdys, i_w_addrs, i_w_datas,
      input  i_dram_ack, i_dramrd_rdy, i_dramrd_data, i_rd_acks,
      output o_ra_acks, o_w_acks, o_dram_rdy, o_dram_we, o_dram_addr,
      output o_dram_wdata, o_dramrd_ack, o_rd_rdys, o_rd_data, o_err
   );

   modport master (
`ifdef DRAM_ARB_STAT_EN
      input  o_grant_cnts,
`endif
      output i_ra_rdys, i_ra_addrs, i_w_rdys, i_w_addrs, i_w_datas,
      output i_dram_ack, i_dramrd_rdy, i_dramrd_data, i_rd_acks,
      input  o_ra_acks, o_w_acks, o_dram_rdy, o_dram_we, o_dram_addr,
      input  o_dram_wdata, o_dramrd_ack, o_rd_rdys, o_rd_data, o_err
   );
endinterface

// File: rtl/dram_arbiter.sv
// dram_arbiter: round-robin arbitration of per-core read/write requests onto
// one registered DRAM command slot, with an in-order ID FIFO that steers
// returning read lines back to the issuing core.
// Optional: define DRAM_ARB_STAT_EN to add saturating per-core grant counters
// on o_grant_cnts.
module dram_arbiter #(
   parameter int N_REQ   = 4,
   parameter int ADDR_BW = 32,
   parameter int LINE_BW = 512,
   parameter int MAX_OUT = 8
) (
   input  logic          i_clk,
   input  logic          i_rst,
   dram_arbiter_if.slave bus
);
   localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int AW = $clog2(MAX_OUT);
   localparam int PW = AW + 1;

   logic               cmd_vld_q, cmd_vld_d;
   logic               cmd_we_q, cmd_we_d;
   logic [ADDR_BW-1:0] cmd_addr_q, cmd_addr_d;
   logic [LINE_BW-1:0] cmd_wdata_q, cmd_wdata_d;
   logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
   logic [PW-1:0]      wr_ptr_q, rd_ptr_q;
   logic [IW-1:0]      id_mem_q [MAX_OUT];
   logic               err_q;

   logic               fifo_full, fifo_empty, slot_free;
   logic [N_REQ-1:0]   elig;
   logic [IW-1:0]      cand, grant_idx, head;
   logic               grant_hit, grant_vld, grant_we;
   logic               ret_vld, push, pop;

   // Extra pointer MSB distinguishes full from empty when the index bits match.
   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign slot_free  = ~cmd_vld_q | bus.i_dram_ack;

   // Round-robin search for the first eligible core after the last winner.
   always_comb begin
      elig      = '0;
      cand      = '0;
      grant_idx = '0;
      grant_hit = 1'b0;
      for (int k = 0; k < N_REQ; k++)
         elig[k] = bus.i_w_rdys[k] | (bus.i_ra_rdys[k] & ~fifo_full);
      for (int i = 1; i <= N_REQ; i++) begin
         cand = IW'((int'(rr_ptr_q) + i) % N_REQ);
         if (!grant_hit && elig[cand]) begin
            grant_hit = 1'b1;
            grant_idx = cand;
         end
      end
   end

   // A write beats a read from the same core; no grants while in reset.
   assign grant_vld = ~i_rst & slot_free & grant_hit;
   assign grant_we  = bus.i_w_rdys[grant_idx];
   assign push      = grant_vld & ~grant_we;

   assign bus.o_w_acks  = (grant_vld &  grant_we) ? (N_REQ'(1) << grant_idx) : '0;
   assign bus.o_ra_acks = (grant_vld & ~grant_we) ? (N_REQ'(1) << grant_idx) : '0;

   // Return path: the FIFO head owns whatever line DRAM presents next.
   assign head             = id_mem_q[rd_ptr_q[AW-1:0]];
   assign ret_vld          = bus.i_dramrd_rdy & ~fifo_empty;
   assign pop              = ret_vld & bus.i_rd_acks[head];
   assign bus.o_rd_rdys    = ret_vld ? (N_REQ'(1) << head) : '0;
   assign bus.o_dramrd_ack = bus.i_rd_acks[head] & ~fifo_empty;
   assign bus.o_rd_data    = bus.i_dramrd_data;

   assign bus.o_dram_rdy   = cmd_vld_q;
   assign bus.o_dram_we    = cmd_we_q;
   assign bus.o_dram_addr  = cmd_addr_q;
   assign bus.o_dram_wdata = cmd_wdata_q;
   assign bus.o_err        = err_q;

   // Load the command slot on a grant, otherwise drop valid once accepted.
   always_comb begin
      cmd_vld_d   = cmd_vld_q;
      cmd_we_d    = cmd_we_q;
      cmd_addr_d  = cmd_addr_q;
      cmd_wdata_d = cmd_wdata_q;
      rr_ptr_d    = rr_ptr_q;
      if (grant_vld) begin
         cmd_vld_d = 1'b1;
         cmd_we_d  = grant_we;
         rr_ptr_d  = grant_idx;
         if (grant_we) begin
            cmd_addr_d  = bus.i_w_addrs[grant_idx*ADDR_BW +: ADDR_BW];
            cmd_wdata_d = bus.i_w_datas[grant_idx*LINE_BW +: LINE_BW];
         end else begin
            cmd_addr_d  = bus.i_ra_addrs[grant_idx*ADDR_BW +: ADDR_BW];
         end
      end else if (bus.i_dram_ack) begin
         cmd_vld_d = 1'b0;
      end
   end

   // Command slot, round-robin pointer, FIFO pointers and sticky error.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         cmd_vld_q   <= 1'b0;
         cmd_we_q    <= 1'b0;
         cmd_addr_q  <= '0;
         cmd_wdata_q <= '0;
         rr_ptr_q    <= IW'(N_REQ - 1);
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         err_q       <= 1'b0;
      end else begin
         cmd_vld_q   <= cmd_vld_d;
         cmd_we_q    <= cmd_we_d;
         cmd_addr_q  <= cmd_addr_d;
         cmd_wdata_q <= cmd_wdata_d;
         rr_ptr_q    <= rr_ptr_d;
         if (push)
            wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop)
            rd_ptr_q <= rd_ptr_q + PW'(1);
         if (bus.i_dramrd_rdy && fifo_empty)
            err_q <= 1'b1;
      end
   end

   // ID storage is pure data; the pointers alone define occupancy.
   always_ff @(posedge i_clk) begin
      if (push)
         id_mem_q[wr_ptr_q[AW-1:0]] <= grant_idx;
   end

`ifdef DRAM_ARB_STAT_EN
   logic [15:0] grant_cnt_q [N_REQ];

   // Count accepted ra/w requests per core, holding at all-ones.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int k = 0; k < N_REQ; k++)
            grant_cnt_q[k] <= '0;
      end else if (grant_vld && (grant_cnt_q[grant_idx] != 16'hFFFF)) begin
         grant_cnt_q[grant_idx] <= grant_cnt_q[grant_idx] + 16'd1;
      end
   end

   for (genvar k = 0; k < N_REQ; k++) begin : g_cnt
      assign bus.o_grant_cnts[k*16 +: 16] = grant_cnt_q[k];
   end
`endif
endmodule

// File: doc/dram_arbiter.md
Name: dram_arbiter

Overview:
- Shares one DRAM command channel and one read-data return channel among the N_REQ cores of the multi-core top.
- Each core presents a read-address (ra) and a write (w) request; the block round-robins them into a registered downstream command.
- It tracks outstanding read owners in an in-order ID FIFO and steers returning read lines back to the issuing core.
- All links use the rdy/ack handshake: a transfer happens in any cycle where rdy&ack is high.

Parameters:
- N_REQ, 4, number of requesting cores (N_TAU).
- ADDR_BW, 32, DRAM address width (GLOBAL_ADDR_BW).
- LINE_BW, 512, width of one DRAM line (DATA_BW*CACHE_SIZE).
- MAX_OUT, 8, maximum outstanding reads; ID FIFO depth, power of 2.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset, asynchronous, active-high.
- i_ra_rdys  in  N_REQ  per-core read-address request.
- o_ra_acks  out  N_REQ  per-core read-address accept.
- i_ra_addrs  in  N_REQ*ADDR_BW  per-core read address.
- i_w_rdys  in  N_REQ  per-core write request.
- o_w_acks  out  N_REQ  per-core write accept.
- i_w_addrs  in  N_REQ*ADDR_BW  per-core write address.
- i_w_datas  in  N_REQ*LINE_BW  per-core write line.
- o_dram_rdy  out  1  downstream command valid.
- i_dram_ack  in  1  downstream command accept.
- o_dram_we  out  1  1=write, 0=read.
- o_dram_addr  out  ADDR_BW  command address.
- o_dram_wdata  out  LINE_BW  write line.
- i_dramrd_rdy  in  1  returning read line valid.
- o_dramrd_ack  out  1  returning read line accept.
- i_dramrd_data  in  LINE_BW  returning read line.
- o_rd_rdys  out  N_REQ  per-core read-data valid.
- i_rd_acks  in  N_REQ  per-core read-data accept.
- o_rd_data  out  LINE_BW  read line, broadcast to all cores.
- o_err  out  1  sticky protocol error.

Behaviour:
- Reset: o_dram_rdy=0, o_dram_we=0, o_dram_addr=0, o_dram_wdata=0, o_err=0. ID FIFO is empty. rr_ptr=N_REQ-1, so core 0 wins first. All acks and o_rd_rdys are 0.
- Reset mid-operation discards the held command and all outstanding IDs immediately.
- Slot free: slot_free = !o_dram_rdy | i_dram_ack.
- Per-core eligibility: a core is eligible if i_w_rdys[k], or if i_ra_rdys[k] & !fifo_full.
- Within a core, write beats read. A read is blocked while the FIFO is full, even if a pop happens in the same cycle.
- Grant is a round-robin search starting at rr_ptr+1 mod N_REQ.
- When slot_free and some core g is eligible, in that same cycle:
  - o_w_acks[g]=1 or o_ra_acks[g]=1 (combinational, one-hot at most).
  - The command registers load at the next edge, and o_dram_rdy=1 next cycle (1-cycle latency).
  - rr_ptr<=g.
  - On a read, g is pushed into the ID FIFO.
- The command is held stable while o_dram_rdy & !i_dram_ack.
- On ack with no eligible core, o_dram_rdy<=0. Back-to-back grants are allowed, giving 1 command per cycle of throughput.
- Return path: head = FIFO head.
  - o_rd_rdys[head] = i_dramrd_rdy & !fifo_empty; all other bits are 0.
  - o_dramrd_ack = i_rd_acks[head] & !fifo_empty.
  - o_rd_data = i_dramrd_data.
  - Pop on o_rd_rdys[head]&i_rd_acks[head].
- Push and pop may occur in the same cycle; occupancy is then unchanged.
- i_dramrd_rdy while fifo_empty: never ack, and o_err<=1 (sticky until reset).
- Pointer width: log2(MAX_OUT)+1 bits. Full = MSBs differ and LSBs equal; pointers wrap naturally.

Optional Feature:
- DRAM_ARB_STAT_EN defined: adds output o_grant_cnts, N_REQ*16 bits.
  - Per-core saturating counter, incremented on every accepted ra or w of that core.
  - Reset to 0; holds at 16'hFFFF when saturated.
- Undefined: the port and counters are absent; all other behaviour is identical.

Test Plan:
- Reset: after i_rst=1 pulse, all outputs are 0 and o_ra_acks=0 even with i_ra_rdys=4'hF.
- Round robin: all 4 cores request reads continuously, i_dram_ack=1 → grant order 0,1,2,3,0. One command per cycle; o_dram_rdy rises 1 cycle after the first ack.
- Priority and backpressure:
  - Core 1 has w(addr 0x100) and ra(0x200) simultaneously → write issued first, read on core 1's next turn.
  - i_dram_ack held 0 for 5 cycles → command stable and no new acks.
- FIFO full: 8 reads accepted with no returns → 9th read not acked while a write from core 2 is still granted. One return popped → read accepted the next cycle.
- Return routing: reads issued by cores 3,0,2 → returned lines are delivered in order to o_rd_rdys=4'b1000,0001,0100. i_rd_acks[0]=0 stalls o_dramrd_ack.
- Error / stats: i_dramrd_rdy=1 with FIFO empty → o_err=1 and sticky, o_dramrd_ack=0. With DRAM_ARB_STAT_EN, 3 grants to core 1 → o_grant_cnts[1]=3.
